test_sequencer: RTL and testbench
=================================

Name: test_sequencer

Overview:
Synthesizable, parametrised sequencer that launches up to NUM_TESTS self-checking sub-blocks one at a time and collects their results. Each test gets a one-cycle start pulse. The sequencer then waits for that test's done, bounded by a per-test watchdog, and records pass/fail/timeout. It sits above the per-block testbenches, or on-chip BIST engines, and reports suite results through counters and per-test result vectors.

Parameters:
NUM_TESTS, 7, number of attached tests; must be >= 1.
TIMEOUT_CYCLES, 1_000_000, maximum number of WAIT cycles per test before a timeout is declared; must be >= 2.
IDXW, $clog2(NUM_TESTS) (minimum 1), width of the test index.
CNTW, IDXW+1, width of the counters and of num_to_run.

Ports:
clk  in  1  system clock.
rst  in  1  asynchronous, active-high reset.
go  in  1  suite start pulse; sampled in IDLE only.
start_idx  in  IDXW  first test to run; latched on go.
num_to_run  in  CNTW  number of tests to run; 0 = run all tests from start_idx to NUM_TESTS-1; latched on go.
stop_on_fail  in  1  1 = end the suite after the first fail or timeout; latched on go.
abort  in  1  level; ends the suite immediately.
test_start  out  NUM_TESTS  one-hot start pulse to the current test.
test_done  in  NUM_TESTS  per-test done.
test_passed  in  NUM_TESTS  per-test pass flag; valid when the matching test_done is high.
busy  out  1  high from LAUNCH through DONE.
suite_done  out  1  one-cycle pulse at the end of the suite.
cfg_err  out  1  start_idx >= NUM_TESTS at go; sticky until the next go.
curr_test  out  IDXW  index of the running or last-run test.
passed_cnt  out  CNTW  number of tests that passed.
failed_cnt  out  CNTW  number of tests that failed; includes timeouts.
timeout_cnt  out  CNTW  number of tests that timed out.
run_vec  out  NUM_TESTS  bit set for each test that completed (done or timeout).
pass_vec  out  NUM_TESTS  bit set for each test that passed.

Behaviour:
- Reset (asynchronous): state=IDLE. All outputs 0, watchdog 0, curr_test=0.
- States: IDLE, LAUNCH, WAIT, DONE.
- IDLE, on go:
  - Latch start_idx, num_to_run and stop_on_fail.
  - Clear counters, run_vec, pass_vec and cfg_err; curr_test<=start_idx.
  - If start_idx >= NUM_TESTS: cfg_err<=1, go to DONE. Otherwise go to LAUNCH.
  - go outside IDLE is ignored.
- LAUNCH (exactly 1 cycle): test_start[curr_test]=1, all other bits 0. Watchdog<=0. Go to WAIT.
- WAIT: watchdog increments each cycle.
  - Only test_done[curr_test] is observed; done bits of other tests are ignored. A done asserted during LAUNCH is ignored.
  - On test_done[curr_test]: set run_vec[curr_test]. If test_passed[curr_test]: passed_cnt++ and set pass_vec bit. Else: failed_cnt++.
  - Else if watchdog == TIMEOUT_CYCLES-1: failed_cnt++, timeout_cnt++, set run_vec bit; pass_vec bit stays 0.
  - Done and timeout in the same cycle: done wins.
  - After a completion, end the suite (go to DONE) if any of these holds: curr_test == NUM_TESTS-1; completed count reaches the latched num_to_run (when nonzero); stop_on_fail is latched and this test failed or timed out.
  - Otherwise curr_test++ and go to LAUNCH.
  - Latency: done sampled at edge k; counters visible and next test_start asserted in cycle k+1.
- DONE (1 cycle): suite_done=1, busy=1. Next state is IDLE. curr_test, counters and vectors hold until the next go.
- abort in LAUNCH or WAIT: go to DONE next cycle. The current test is not counted and its run_vec bit stays 0. abort in IDLE or DONE has no effect.
- Arithmetic: counters are CNTW wide and cannot overflow, because at most NUM_TESTS completions occur per suite. Watchdog width is $clog2(TIMEOUT_CYCLES).
- busy is asserted in LAUNCH, WAIT and DONE; 0 in IDLE.
- Reset asserted mid-suite returns the block to IDLE immediately, with all results cleared.

Test Plan:
1. NUM_TESTS=7, go with start_idx=0, num_to_run=0; tests 0..6 assert done 20 cycles after start with passed=1 except test 3 (passed=0) -> exactly 7 test_start pulses in order, passed_cnt=6, failed_cnt=1, pass_vec=7'b1110111, run_vec=7'h7F, one suite_done pulse.
2. start_idx=2, num_to_run=3, all pass -> starts issued only to tests 2, 3, 4; run_vec=7'b0011100; passed_cnt=3; curr_test=4.
3. TIMEOUT_CYCLES=50; test 1 never asserts done -> test 1 times out exactly 50 WAIT cycles after its start; timeout_cnt=1, failed_cnt=1; test 2 start follows 1 cycle later.
4. stop_on_fail=1, test 2 fails -> no test_start for tests 3..6; suite_done 1 cycle after test 2's done; failed_cnt=1, passed_cnt=2.
5. Spurious test_done[5] while test 0 runs, plus test_done[0] asserted during LAUNCH -> both ignored; test 0 completes only on its later done; a done coinciding with watchdog expiry is counted as a pass, with timeout_cnt=0.
6. abort during test 4's WAIT -> suite_done next cycle, run_vec[4]=0. Separately: start_idx=7 -> cfg_err=1, suite_done 1 cycle after go, all counters 0. Separately: rst mid-WAIT -> IDLE, all outputs 0.

Source files
------------

// File: rtl/test_sequencer_if.sv
// Test launch bus between the sequencer and its attached self-checking tests.
//   test_start  : one-hot, one-cycle start pulse (sequencer -> tests)
//   test_done   : per-test completion flag (tests -> sequencer)
//   test_passed : per-test result, qualified by the matching test_done bit
// There is no backpressure. A start pulse is a request. The matching
// test_done bit is the single response. test_passed is meaningful only in
// a cycle where that test_done bit is high.
interface test_sequencer_if #(
  parameter int NUM_TESTS = 7
);
  logic [NUM_TESTS-1:0] test_start;
  logic [NUM_TESTS-1:0] test_done;
  logic [NUM_TESTS-1:0] test_passed;

  modport master (output test_start, input test_done, input test_passed);
  modport slave  (input test_start, output test_done, output test_passed);
endinterface

// File: rtl/test_sequencer.sv
// Suite sequencer: launches attached tests one at a time, waits for each
// test's done under a per-test watchdog, and records pass/fail/timeout.
// Ports:
//   clk, rst          : clock, asynchronous active-high reset
//   go                : suite start pulse (sampled in IDLE only)
//   start_idx         : first test to run (latched on go)
//   num_to_run        : tests to run, 0 = through the last test (latched on go)
//   stop_on_fail      : end suite on first fail/timeout (latched on go)
//   abort             : level, ends the suite without counting the current test
//   tbus              : test launch bus (master side)
//   busy, suite_done  : activity flag, one-cycle end-of-suite pulse
//   cfg_err           : start_idx out of range at go, sticky until next go
//   curr_test         : running or last-run test index
//   passed_cnt, failed_cnt, timeout_cnt : suite counters
//   run_vec, pass_vec : per-test completed / passed bits
//   dbg_state         : current FSM state encoding
module test_sequencer #(
  parameter int NUM_TESTS      = 7,
  parameter int TIMEOUT_CYCLES = 1_000_000,
  parameter int IDXW           = (NUM_TESTS > 1) ? $clog2(NUM_TESTS) : 1,
  parameter int CNTW           = IDXW + 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 go,
  input  logic [IDXW-1:0]      start_idx,
  input  logic [CNTW-1:0]      num_to_run,
  input  logic                 stop_on_fail,
  input  logic                 abort,
  test_sequencer_if.master     tbus,
  output logic                 busy,
  output logic                 suite_done,
  output logic                 cfg_err,
  output logic [IDXW-1:0]      curr_test,
  output logic [CNTW-1:0]      passed_cnt,
  output logic [CNTW-1:0]      failed_cnt,
  output logic [CNTW-1:0]      timeout_cnt,
  output logic [NUM_TESTS-1:0] run_vec,
  output logic [NUM_TESTS-1:0] pass_vec,
  output logic [1:0]           dbg_state
);

  localparam int              WDW      = $clog2(TIMEOUT_CYCLES);
  localparam logic [WDW-1:0]  WD_LAST  = WDW'(TIMEOUT_CYCLES - 1);
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NUM_TESTS - 1);
  localparam logic [CNTW-1:0] NT_CNT   = CNTW'(NUM_TESTS);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LAUNCH = 2'd1,
    S_WAIT   = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  state_t          state, state_nxt;
  logic [CNTW-1:0] ntr_q;
  logic            sof_q;
  logic [WDW-1:0]  wdog;

  logic            cur_done, cur_pass, wd_expired;
  logic            complete, test_ok, timed_out, suite_end, bad_start;
  logic [CNTW-1:0] completed_next;

  // Only the current test's done is looked at; other done bits are ignored.
  always_comb begin
    cur_done       = tbus.test_done[curr_test];
    cur_pass       = tbus.test_passed[curr_test];
    wd_expired     = (wdog == WD_LAST);
    // abort takes priority: the test in flight is not counted.
    complete       = (state == S_WAIT) && !abort && (cur_done || wd_expired);
    test_ok        = cur_done && cur_pass;
    // A done in the expiry cycle wins over the timeout.
    timed_out      = !cur_done && wd_expired;
    completed_next = passed_cnt + failed_cnt + CNTW'(1);
    suite_end      = (curr_test == LAST_IDX) ||
                     ((ntr_q != '0) && (completed_next == ntr_q)) ||
                     (sof_q && !test_ok);
    bad_start      = ({1'b0, start_idx} >= NT_CNT);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt       = state;
    tbus.test_start = '0;
    case (state)
      S_IDLE: begin
        if (go) state_nxt = bad_start ? S_DONE : S_LAUNCH;
      end
      S_LAUNCH: begin
        tbus.test_start[curr_test] = 1'b1;
        state_nxt = abort ? S_DONE : S_WAIT;
      end
      S_WAIT: begin
        if (abort)         state_nxt = S_DONE;
        else if (complete) state_nxt = suite_end ? S_DONE : S_LAUNCH;
      end
      S_DONE: state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  assign busy       = (state != S_IDLE);
  assign suite_done = (state == S_DONE);
  assign dbg_state  = state;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ntr_q       <= '0;
      sof_q       <= 1'b0;
      wdog        <= '0;
      cfg_err     <= 1'b0;
      curr_test   <= '0;
      passed_cnt  <= '0;
      failed_cnt  <= '0;
      timeout_cnt <= '0;
      run_vec     <= '0;
      pass_vec    <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (go) begin
            ntr_q       <= num_to_run;
            sof_q       <= stop_on_fail;
            cfg_err     <= bad_start;
            curr_test   <= start_idx;
            passed_cnt  <= '0;
            failed_cnt  <= '0;
            timeout_cnt <= '0;
            run_vec     <= '0;
            pass_vec    <= '0;
          end
        end
        S_LAUNCH: wdog <= '0;
        S_WAIT: begin
          // Wrap is harmless: expiry always leaves WAIT.
          wdog <= wdog + WDW'(1);
          if (complete) begin
            run_vec[curr_test] <= 1'b1;
            if (test_ok) begin
              passed_cnt         <= passed_cnt + CNTW'(1);
              pass_vec[curr_test] <= 1'b1;
            end else begin
              failed_cnt <= failed_cnt + CNTW'(1);
            end
            if (timed_out) timeout_cnt <= timeout_cnt + CNTW'(1);
            if (!suite_end) curr_test <= curr_test + IDXW'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_test_sequencer.sv
// Bench for test_sequencer: a responder model plays the attached tests
// (configurable done delay and result per test), a monitor checks every
// start pulse against a queue of expected test indices, and one task per
// scenario checks the suite results.
module tb_test_sequencer;
  localparam int NT   = 7;
  localparam int TO   = 50;
  localparam int IDXW = 3;
  localparam int CNTW = 4;

  logic            clk = 1'b0;
  logic            rst;
  logic            go;
  logic [IDXW-1:0] start_idx;
  logic [CNTW-1:0] num_to_run;
  logic            stop_on_fail;
  logic            abort;
  logic            busy, suite_done, cfg_err;
  logic [IDXW-1:0] curr_test;
  logic [CNTW-1:0] passed_cnt, failed_cnt, timeout_cnt;
  logic [NT-1:0]   run_vec, pass_vec;
  logic [1:0]      dbg_state;

  logic [NT-1:0]   resp_done, resp_pass;
  int              delay_cfg[NT];
  logic [NT-1:0]   pass_cfg;
  bit              glitch_en;
  int              cnt[NT];

  logic [IDXW-1:0] exp_q[$];
  int              tests_run, fail_cnt;
  int              cyc;
  int              start_cyc[NT];
  int              sd_pulses;

  always #5 clk = ~clk;

  test_sequencer_if #(.NUM_TESTS(NT)) tbus ();
  assign tbus.test_done   = resp_done;
  assign tbus.test_passed = resp_pass;

  test_sequencer #(.NUM_TESTS(NT), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst), .go(go), .start_idx(start_idx),
    .num_to_run(num_to_run), .stop_on_fail(stop_on_fail), .abort(abort),
    .tbus(tbus), .busy(busy), .suite_done(suite_done), .cfg_err(cfg_err),
    .curr_test(curr_test), .passed_cnt(passed_cnt), .failed_cnt(failed_cnt),
    .timeout_cnt(timeout_cnt), .run_vec(run_vec), .pass_vec(pass_vec),
    .dbg_state(dbg_state)
  );

  always @(posedge clk) cyc <= cyc + 1;

  // Test responder: a start seen in cycle c yields done in cycle c+delay.
  always @(negedge clk) begin
    for (int i = 0; i < NT; i++) begin
      resp_done[i] = 1'b0;
      if (cnt[i] > 0) begin
        cnt[i]--;
        if (cnt[i] == 0) begin
          resp_done[i] = 1'b1;
          resp_pass[i] = pass_cfg[i];
          cnt[i] = -1;
        end
      end
      if (tbus.test_start[i]) begin
        if (delay_cfg[i] > 0) cnt[i] = delay_cfg[i];
        if (glitch_en && i == 0) begin
          resp_done[0] = 1'b1;
          resp_pass[0] = 1'b0;
        end
      end
    end
    if (glitch_en && cnt[0] == 15) begin
      resp_done[5] = 1'b1;
      resp_pass[5] = 1'b0;
    end
  end

  // Start-pulse scoreboard.
  always @(negedge clk) begin
    logic [NT-1:0]   ev;
    logic [IDXW-1:0] e;
    if (suite_done === 1'b1) sd_pulses++;
    if (tbus.test_start !== '0) begin
      for (int i = 0; i < NT; i++) if (tbus.test_start[i]) start_cyc[i] = cyc;
      tests_run++;
      if (exp_q.size() == 0) begin
        fail_cnt++;
        $display("FAIL start_order: got test_start=%b, expected no start", tbus.test_start);
      end else begin
        e = exp_q.pop_front();
        ev = '0;
        ev[e] = 1'b1;
        if (tbus.test_start !== ev) begin
          fail_cnt++;
          $display("FAIL start_order: got test_start=%b, expected %b", tbus.test_start, ev);
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_cfg(input int d);
    for (int i = 0; i < NT; i++) delay_cfg[i] = d;
    pass_cfg = '1;
  endtask

  task automatic start_suite(input logic [IDXW-1:0] si, input logic [CNTW-1:0] n, input logic sof);
    @(negedge clk);
    start_idx = si; num_to_run = n; stop_on_fail = sof; go = 1'b1;
    @(negedge clk);
    go = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    bit ok = 1'b0;
    for (int k = 0; k < budget; k++) begin
      if (suite_done === 1'b1) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    tests_run++;
    if (!ok) begin fail_cnt++; $display("FAIL suite_done_wait: got no pulse, expected one within %0d cycles", budget); end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    tick(2);
    tests_run++; if ({busy, suite_done, cfg_err} !== 3'b000) begin fail_cnt++; $display("FAIL rst_flags: got %b, expected 000", {busy, suite_done, cfg_err}); end
    tests_run++; if ({passed_cnt, failed_cnt, timeout_cnt, curr_test} !== '0) begin fail_cnt++; $display("FAIL rst_counters: got %h, expected 0", {passed_cnt, failed_cnt, timeout_cnt, curr_test}); end
    tests_run++; if ({run_vec, pass_vec, tbus.test_start} !== '0) begin fail_cnt++; $display("FAIL rst_vectors: got %h, expected 0", {run_vec, pass_vec, tbus.test_start}); end
    rst = 1'b0;
    tick(2);
  endtask

  task automatic test_full_suite;
    int sd0;
    set_cfg(20);
    pass_cfg[3] = 1'b0;
    for (int i = 0; i < NT; i++) exp_q.push_back(IDXW'(i));
    sd0 = sd_pulses;
    start_suite(3'd0, 4'd0, 1'b0);
    wait_done(1000);
    tests_run++; if (passed_cnt !== 4'd6) begin fail_cnt++; $display("FAIL full_passed: got %0d, expected 6", passed_cnt); end
    tests_run++; if (failed_cnt !== 4'd1) begin fail_cnt++; $display("FAIL full_failed: got %0d, expected 1", failed_cnt); end
    tests_run++; if (pass_vec !== 7'b1110111) begin fail_cnt++; $display("FAIL full_pass_vec: got %b, expected 1110111", pass_vec); end
    tests_run++; if (run_vec !== 7'h7F) begin fail_cnt++; $display("FAIL full_run_vec: got %b, expected 1111111", run_vec); end
    tests_run++; if (curr_test !== 3'd6) begin fail_cnt++; $display("FAIL full_curr_test: got %0d, expected 6", curr_test); end
    tests_run++; if (start_cyc[1] - start_cyc[0] !== 21) begin fail_cnt++; $display("FAIL full_latency: got %0d, expected 21", start_cyc[1] - start_cyc[0]); end
    tick(1);
    tests_run++; if (sd_pulses - sd0 !== 1) begin fail_cnt++; $display("FAIL full_sd_pulses: got %0d, expected 1", sd_pulses - sd0); end
    tests_run++; if (busy !== 1'b0) begin fail_cnt++; $display("FAIL full_busy_idle: got %b, expected 0", busy); end
    tests_run++; if (exp_q.size() != 0) begin fail_cnt++; $display("FAIL full_starts: got %0d missing starts, expected 0", exp_q.size()); end
    exp_q.delete();
  endtask

  task automatic test_partial;
    set_cfg(5);
    for (int i = 2; i <= 4; i++) exp_q.push_back(IDXW'(i));
    start_suite(3'd2, 4'd3, 1'b0);
    wait_done(500);
    tests_run++; if (run_vec !== 7'b0011100) begin fail_cnt++; $display("FAIL part_run_vec: got %b, expected 0011100", run_vec); end
    tests_run++; if (passed_cnt !== 4'd3) begin fail_cnt++; $display("FAIL part_passed: got %0d, expected 3", passed_cnt); end
    tests_run++; if (curr_test !== 3'd4) begin fail_cnt++; $display("FAIL part_curr_test: got %0d, expected 4", curr_test); end
    tick(2);
    tests_run++; if (exp_q.size() != 0) begin fail_cnt++; $display("FAIL part_starts: got %0d missing starts, expected 0", exp_q.size()); end
    exp_q.delete();
  endtask

  task automatic test_timeout;
    set_cfg(10);
    delay_cfg[1] = -1;
    for (int i = 0; i <= 2; i++) exp_q.push_back(IDXW'(i));
    start_suite(3'd0, 4'd3, 1'b0);
    wait_done(500);
    tests_run++; if (timeout_cnt !== 4'd1) begin fail_cnt++; $display("FAIL to_timeout_cnt: got %0d, expected 1", timeout_cnt); end
    tests_run++; if (failed_cnt !== 4'd1) begin fail_cnt++; $display("FAIL to_failed: got %0d, expected 1", failed_cnt); end
    tests_run++; if (passed_cnt !== 4'd2) begin fail_cnt++; $display("FAIL to_passed: got %0d, expected 2", passed_cnt); end
    tests_run++; if ({run_vec, pass_vec} !== {7'b0000111, 7'b0000101}) begin fail_cnt++; $display("FAIL to_vectors: got run=%b pass=%b, expected 0000111/0000101", run_vec, pass_vec); end
    tests_run++; if (start_cyc[2] - start_cyc[1] !== TO + 1) begin fail_cnt++; $display("FAIL to_timing: got %0d, expected %0d", start_cyc[2] - start_cyc[1], TO + 1); end
    tick(2);
    exp_q.delete();
  endtask

  task automatic test_stop_on_fail;
    set_cfg(10);
    pass_cfg[2] = 1'b0;
    for (int i = 0; i <= 2; i++) exp_q.push_back(IDXW'(i));
    start_suite(3'd0, 4'd0, 1'b1);
    wait_done(500);
    tests_run++; if (cyc - start_cyc[2] !== 11) begin fail_cnt++; $display("FAIL sof_timing: got %0d, expected 11", cyc - start_cyc[2]); end
    tests_run++; if ({passed_cnt, failed_cnt} !== {4'd2, 4'd1}) begin fail_cnt++; $display("FAIL sof_counts: got passed=%0d failed=%0d, expected 2/1", passed_cnt, failed_cnt); end
    tests_run++; if (run_vec !== 7'b0000111) begin fail_cnt++; $display("FAIL sof_run_vec: got %b, expected 0000111", run_vec); end
    tick(30);
    exp_q.delete();
  endtask

  task automatic test_spurious_done;
    set_cfg(30);
    glitch_en = 1'b1;
    exp_q.push_back(3'd0);
    start_suite(3'd0, 4'd1, 1'b0);
    wait_done(200);
    glitch_en = 1'b0;
    tests_run++; if ({passed_cnt, failed_cnt} !== {4'd1, 4'd0}) begin fail_cnt++; $display("FAIL spur_counts: got passed=%0d failed=%0d, expected 1/0", passed_cnt, failed_cnt); end
    tests_run++; if (cyc - start_cyc[0] !== 31) begin fail_cnt++; $display("FAIL spur_timing: got %0d, expected 31", cyc - start_cyc[0]); end
    tests_run++; if ({run_vec, pass_vec} !== {7'b0000001, 7'b0000001}) begin fail_cnt++; $display("FAIL spur_vectors: got run=%b pass=%b, expected 0000001/0000001", run_vec, pass_vec); end
    tick(3);
    // Done arriving in the watchdog expiry cycle.
    set_cfg(TO);
    exp_q.push_back(3'd1);
    start_suite(3'd1, 4'd1, 1'b0);
    wait_done(200);
    tests_run++; if ({passed_cnt, failed_cnt, timeout_cnt} !== {4'd1, 4'd0, 4'd0}) begin fail_cnt++; $display("FAIL edge_counts: got p=%0d f=%0d t=%0d, expected 1/0/0", passed_cnt, failed_cnt, timeout_cnt); end
    tests_run++; if (pass_vec !== 7'b0000010) begin fail_cnt++; $display("FAIL edge_pass_vec: got %b, expected 0000010", pass_vec); end
    tests_run++; if (cyc - start_cyc[1] !== TO + 1) begin fail_cnt++; $display("FAIL edge_timing: got %0d, expected %0d", cyc - start_cyc[1], TO + 1); end
    tick(3);
    exp_q.delete();
  endtask

  task automatic test_abort_cfg_rst;
    set_cfg(40);
    exp_q.push_back(3'd4);
    start_suite(3'd4, 4'd0, 1'b0);
    tick(10);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    tests_run++; if (suite_done !== 1'b1) begin fail_cnt++; $display("FAIL abort_sd: got %b, expected 1", suite_done); end
    tests_run++; if ({run_vec, passed_cnt, failed_cnt} !== '0) begin fail_cnt++; $display("FAIL abort_results: got run=%b p=%0d f=%0d, expected 0/0/0", run_vec, passed_cnt, failed_cnt); end
    tick(50);
    exp_q.delete();

    start_suite(3'd7, 4'd0, 1'b0);
    tests_run++; if ({suite_done, cfg_err} !== 2'b11) begin fail_cnt++; $display("FAIL cfg_sd_err: got %b, expected 11", {suite_done, cfg_err}); end
    tests_run++; if ({passed_cnt, failed_cnt, timeout_cnt, run_vec} !== '0) begin fail_cnt++; $display("FAIL cfg_counts: got %h, expected 0", {passed_cnt, failed_cnt, timeout_cnt, run_vec}); end
    tick(3);
    tests_run++; if ({cfg_err, busy} !== 2'b10) begin fail_cnt++; $display("FAIL cfg_sticky: got %b, expected 10", {cfg_err, busy}); end

    set_cfg(40);
    delay_cfg[0] = 3;
    exp_q.push_back(3'd0);
    exp_q.push_back(3'd1);
    start_suite(3'd0, 4'd0, 1'b0);
    tests_run++; if (cfg_err !== 1'b0) begin fail_cnt++; $display("FAIL cfg_clear: got %b, expected 0", cfg_err); end
    tick(15);
    tests_run++; if (run_vec !== 7'b0000001) begin fail_cnt++; $display("FAIL rst_pre: got %b, expected 0000001", run_vec); end
    rst = 1'b1;
    #1;
    tests_run++; if ({busy, dbg_state, run_vec, pass_vec, passed_cnt, curr_test} !== '0) begin fail_cnt++; $display("FAIL rst_mid: got %h, expected 0", {busy, dbg_state, run_vec, pass_vec, passed_cnt, curr_test}); end
    @(negedge clk);
    rst = 1'b0;
    tick(50);
    exp_q.delete();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got no finish, expected finish by 2ms");
    $fatal(1, "global timeout");
  end

  initial begin
    tests_run = 0; fail_cnt = 0; cyc = 0; sd_pulses = 0;
    go = 1'b0; start_idx = '0; num_to_run = '0; stop_on_fail = 1'b0; abort = 1'b0;
    resp_done = '0; resp_pass = '0; glitch_en = 1'b0;
    for (int i = 0; i < NT; i++) begin cnt[i] = -1; start_cyc[i] = 0; end
    set_cfg(20);
    test_reset();
    test_full_suite();
    test_partial();
    test_timeout();
    test_stop_on_fail();
    test_spurious_done();
    test_abort_cfg_rst();
    $display("[TB] %0d tests run, %0d failed", tests_run, fail_cnt);
    $finish;
  end

endmodule
